// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered RV32 branch resolution with a valid/ready
// handshake, misprediction detection and saturating perf counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_redirect_pc,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic cond_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic cond_eval(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic res;
    case (f3)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b100:  res = ($signed(a) <  $signed(b));
      3'b101:  res = ($signed(a) >= $signed(b));
      3'b110:  res = (a <  b);
      3'b111:  res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic            valid_q, valid_d;
  logic            taken_q, mispredict_q, illegal_q, misaligned_q;
  logic [XLEN-1:0] target_q, redirect_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic            legal_s, taken_s, mispredict_s, misaligned_s;
  logic [XLEN-1:0] target_s, seq_pc_s, redirect_s;
  logic            accept_s, out_hs_s;

  // Evaluate the incoming branch; illegal encodings resolve as not-taken.
  always_comb begin
    legal_s      = cond_legal(in_funct3);
    taken_s      = legal_s && cond_eval(in_funct3, in_rs1, in_rs2);
    target_s     = in_pc + in_imm;
    seq_pc_s     = in_pc + PC_STEP;
    if (taken_s) begin
      redirect_s = target_s;
    end else begin
      redirect_s = seq_pc_s;
    end
    mispredict_s = legal_s && (taken_s != in_pred_taken);
    misaligned_s = taken_s && (target_s[1:0] != 2'b00);
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  // A flushed result leaves without a handshake, so it is never counted.
  assign out_hs_s = valid_q && out_ready && !flush;

  // Next-state for the result-valid flag and the perf counters.
  always_comb begin
    valid_d   = valid_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
    end else if (out_hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (cnt_clear) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (out_hs_s && !illegal_q) begin
      if (br_cnt_q != CNT_MAX) begin
        br_cnt_d = br_cnt_q + CNT_ONE;
      end else begin
        br_cnt_d = br_cnt_q;
      end
      if (mispredict_q && (mis_cnt_q != CNT_MAX)) begin
        mis_cnt_d = mis_cnt_q + CNT_ONE;
      end else begin
        mis_cnt_d = mis_cnt_q;
      end
    end else begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Valid flag and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  // Result registers load only on accept and otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
    end else if (accept_s) begin
      taken_q      <= taken_s;
      mispredict_q <= mispredict_s;
      illegal_q    <= !legal_s;
      misaligned_q <= misaligned_s;
      target_q     <= target_s;
      redirect_q   <= redirect_s;
    end
  end

  assign out_valid       = valid_q;
  assign out_taken       = taken_q;
  assign out_mispredict  = mispredict_q;
  assign out_illegal     = illegal_q;
  assign out_misaligned  = misaligned_q;
  assign out_target      = target_q;
  assign out_redirect_pc = redirect_q;
  assign br_count        = br_cnt_q;
  assign mispred_count   = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results are queued on
// accept and compared every cycle while the result is held.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
  logic             in_pred_taken, flush;
  logic             out_valid, out_ready;
  logic             out_taken, out_mispredict, out_illegal, out_misaligned;
  logic [XLEN-1:0]  out_target, out_redirect_pc;
  logic             cnt_clear;
  logic [CNT_W-1:0] br_count, mispred_count;

  typedef struct {
    logic        taken, mis, ill, misal;
    logic [31:0] target, redirect;
  } exp_t;

  exp_t exp_q[$];
  bit   m_valid;
  int   m_br, m_mis;
  bit   last_acc;
  int   n_checks, n_errors;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_misaligned(out_misaligned),
    .out_target(out_target), .out_redirect_pc(out_redirect_pc),
    .cnt_clear(cnt_clear), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed compare done by biasing the sign bit, independent of $signed.
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic p);
    exp_t e;
    logic c, leg;
    logic [31:0] sa, sb;
    sa = a ^ 32'h8000_0000;
    sb = b ^ 32'h8000_0000;
    leg = 1'b1;
    c = 1'b0;
    case (f)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = (sa < sb);
      3'b101:  c = !(sa < sb);
      3'b110:  c = (a < b);
      3'b111:  c = !(a < b);
      default: leg = 1'b0;
    endcase
    e.ill      = !leg;
    e.taken    = c;
    e.target   = pc + imm;
    e.redirect = c ? e.target : pc + 32'd4;
    e.mis      = leg && (c != p);
    e.misal    = c && (e.target[1:0] != 2'b00);
    return e;
  endfunction

  task automatic cycle();
    exp_t e, e_new;
    bit acc, hs, fl;
    @(negedge clk);
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, (!flush && (!m_valid || out_ready))});
    check_eq("br_count", 64'(br_count), 64'(m_br));
    check_eq("mispred_count", 64'(mispred_count), 64'(m_mis));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 64'd0, 64'd1);
      end else begin
        e = exp_q[0];
        check_eq("taken", {63'd0, out_taken}, {63'd0, e.taken});
        check_eq("mispredict", {63'd0, out_mispredict}, {63'd0, e.mis});
        check_eq("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
        check_eq("misaligned", {63'd0, out_misaligned}, {63'd0, e.misal});
        check_eq("target", 64'(out_target), 64'(e.target));
        check_eq("redirect", 64'(out_redirect_pc), 64'(e.redirect));
      end
    end
    acc = in_valid && !flush && (!m_valid || out_ready);
    hs  = m_valid && out_ready && !flush;
    fl  = flush;
    e_new = model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken);
    @(posedge clk);
    #1;
    if (cnt_clear) begin
      m_br = 0;
      m_mis = 0;
    end else if (hs && exp_q.size() > 0 && !exp_q[0].ill) begin
      if (m_br < CMAX) m_br++;
      if (exp_q[0].mis && m_mis < CMAX) m_mis++;
    end
    if (m_valid && (fl || hs)) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 1'b0;
    end
    if (acc) begin
      exp_q.push_back(e_new);
      m_valid = 1'b1;
    end
    last_acc = acc;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic p);
    in_valid = 1'b1; in_funct3 = f; in_rs1 = a; in_rs2 = b;
    in_pc = pc; in_imm = imm; in_pred_taken = p;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Hand over any held result, accept one branch and leave it held.
  task automatic send_hold(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm, input logic p);
    out_ready = 1'b1;
    drive(f, a, b, pc, imm, p);
    cycle();
    idle();
    out_ready = 1'b0;
  endtask

  initial begin
    int idx, snap;
    logic [31:0] bp_pc [3];
    n_checks = 0; n_errors = 0;
    m_valid = 1'b0; m_br = 0; m_mis = 0; last_acc = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_flags", {60'd0, out_taken, out_mispredict, out_illegal, out_misaligned}, 64'd0);
    check_eq("rst_target", 64'(out_target), 64'd0);
    check_eq("rst_redirect", 64'(out_redirect_pc), 64'd0);
    check_eq("rst_counts", {56'd0, br_count, mispred_count}, 64'd0);
    reset = 1'b0;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors: sign split, equality with PC wrap, illegal, misaligned.
    send_hold(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    check_eq("blt_taken", {63'd0, out_taken}, 64'd1);
    check_eq("blt_target", 64'(out_target), 64'h120);
    check_eq("blt_redirect", 64'(out_redirect_pc), 64'h120);
    check_eq("blt_mispred", {63'd0, out_mispredict}, 64'd1);
    send_hold(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    check_eq("bltu_taken", {63'd0, out_taken}, 64'd0);
    check_eq("bltu_redirect", 64'(out_redirect_pc), 64'h104);
    check_eq("bltu_mispred", {63'd0, out_mispredict}, 64'd0);
    send_hold(3'b000, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1);
    check_eq("beq_taken", {63'd0, out_taken}, 64'd1);
    check_eq("beq_target", 64'(out_target), 64'h10);
    check_eq("beq_mispred", {63'd0, out_mispredict}, 64'd0);
    send_hold(3'b001, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1);
    check_eq("bne_taken", {63'd0, out_taken}, 64'd0);
    check_eq("bne_redirect", 64'(out_redirect_pc), 64'hFFFF_FFF4);
    send_hold(3'b010, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1);
    check_eq("ill_flag", {63'd0, out_illegal}, 64'd1);
    check_eq("ill_taken", {62'd0, out_taken, out_mispredict}, 64'd0);
    snap = m_br;
    send_hold(3'b000, 32'h7, 32'h7, 32'h200, 32'h2, 1'b1);
    check_eq("ill_no_count", 64'(br_count), 64'(snap));
    check_eq("misal_flag", {63'd0, out_misaligned}, 64'd1);
    out_ready = 1'b1;
    cycle();

    // Back-pressure: three branches offered, only the first gets in while stalled.
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    check_eq("bp_clr", 64'(br_count), 64'd0);
    bp_pc[0] = 32'h1000; bp_pc[1] = 32'h2000; bp_pc[2] = 32'h3000;
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b101, 32'h3, 32'h9, bp_pc[idx], 32'h40, 1'b1);
      cycle();
      if (last_acc) idx++;
    end
    check_eq("bp_accepts", 64'(idx), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (idx < 3) drive(3'b101, 32'h3, 32'h9, bp_pc[idx], 32'h40, 1'b1);
      else idle();
      cycle();
      if (last_acc) idx++;
      check_eq("bp_br", 64'(br_count), 64'(k));
    end

    // Flush kills a held result and blocks the offered branch.
    send_hold(3'b000, 32'h1, 32'h1, 32'h500, 32'h10, 1'b0);
    snap = m_br;
    drive(3'b001, 32'h1, 32'h2, 32'h600, 32'h10, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    check_eq("fl_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fl_br", 64'(br_count), 64'(snap));
    cycle();

    // Saturation over 17 mispredicted handshakes.
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(3'b000, 32'hA, 32'hA, 32'h800 + 32'(i * 4), 32'h8, 1'b0);
      cycle();
    end
    idle();
    cycle();
    check_eq("sat_br", 64'(br_count), 64'd15);
    check_eq("sat_mis", 64'(mispred_count), 64'd15);

    // Clear coinciding with a handshake wins.
    send_hold(3'b000, 32'h1, 32'h1, 32'h900, 32'h8, 1'b0);
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    check_eq("clr_br", 64'(br_count), 64'd0);
    check_eq("clr_mis", 64'(mispred_count), 64'd0);

    // Random traffic with back-pressure, flushes and clears.
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_funct3 = 3'($urandom_range(0, 7));
      in_rs1 = $urandom();
      in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom();
      in_pc = $urandom();
      in_imm = $urandom();
      in_pred_taken = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      cnt_clear = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; cnt_clear = 1'b0; idle();

    // Async reset while a result is held and counters are nonzero.
    send_hold(3'b000, 32'h2, 32'h2, 32'hA00, 32'h8, 1'b0);
    out_ready = 1'b1;
    drive(3'b000, 32'h2, 32'h2, 32'hB00, 32'h8, 1'b0);
    cycle();
    idle();
    out_ready = 1'b0;
    check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    check_eq("pre_rst_br_nz", {63'd0, (br_count != '0)}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_flags", {60'd0, out_taken, out_mispredict, out_illegal, out_misaligned}, 64'd0);
    check_eq("arst_data", {out_target, out_redirect_pc}, 64'd0);
    check_eq("arst_counts", {56'd0, br_count, mispred_count}, 64'd0);
    exp_q.delete();
    m_valid = 1'b0; m_br = 0; m_mis = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("post_rst_ready", {63'd0, in_ready}, 64'd1);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch resolution stage for the execute pipeline. Accepts one conditional branch per cycle over a valid/ready handshake, evaluates all six RV32 branch conditions, computes the branch target and redirect PC, and flags mispredictions against the fetch-stage prediction. It also keeps saturating branch and misprediction counters for the CSR/perf block. It replaces the purely combinational equal/less-than comparator in the execute stage.

## Interface
- XLEN, 32, operand/PC width (≥ 8)
- CNT_W, 32, width of each perf counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  branch presented
- in_ready  output  1  unit can accept this cycle
- in_funct3  input  3  branch condition (RV32 B-type encoding)
- in_rs1, in_rs2  input  XLEN  operands
- in_pc  input  XLEN  branch PC
- in_imm  input  XLEN  sign-extended B-immediate
- in_pred_taken  input  1  fetch-stage prediction
- flush  input  1  kill held result and block intake this cycle
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_taken, out_mispredict, out_illegal, out_misaligned  output  1 each  result flags
- out_target, out_redirect_pc  output  XLEN  pc+imm; next correct PC
- cnt_clear  input  1  synchronous clear of both counters
- br_count, mispred_count  output  CNT_W  perf counters

## Operation
- Condition decode: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. 010/011 → out_illegal=1, out_taken=0, out_mispredict=0, out_misaligned=0.
- Signed compares are two's complement over the full XLEN. Unsigned compares are magnitude compares. EQ/NE are the same in both modes.
- out_target = (in_pc + in_imm) mod 2^XLEN, wrap-around silent. out_redirect_pc = out_taken ? out_target : (in_pc + 4) mod 2^XLEN.
- out_mispredict = legal && (out_taken != in_pred_taken).
- out_misaligned = out_taken && out_target[1:0] != 0. This flag does not suppress out_mispredict.
- in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Accept: all result fields are registered and out_valid←1.
- Output handshake (out_valid && out_ready) without an accept: out_valid←0. Data fields hold their last value.
- Handshake and accept in the same cycle: the new result replaces the old one, so full throughput is one branch per cycle.
- flush: out_valid←0 next edge regardless of out_ready, and no accept that cycle. A flushed result is never counted.
- Counters update on the output handshake only, for legal results. br_count += 1; mispred_count += 1 if out_mispredict. Each counter saturates at 2^CNT_W−1.
- cnt_clear sets both counters to 0 and wins over a simultaneous increment.
- Output stall (out_valid && !out_ready && !flush): all outputs hold stable.

## Timing
- Reset (async assert, sync-safe deassert via the existing reset tree):
  - out_valid=0, all out_* data/flags=0, br_count=0, mispred_count=0.
  - in_ready=1 on the first cycle after reset, unless flush is high.
- Latency: result visible on out_* one cycle after the accept edge.
- in_ready is combinational from out_valid, out_ready and flush. It has no path from in_valid.
- Counters reflect a handshake on the edge that completes it, so the new value is visible the next cycle.
- Reset mid-operation: the held result is discarded and not counted. Counters return to 0.

## Test plan
- BLT/BLTU sign split: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0.
  - funct3=100 → taken=1, target=0x120, redirect=0x120, mispredict=1.
  - funct3=110 → taken=0, redirect=0x104, mispredict=0.
- Equality and wrap: funct3=000, rs1=rs2=0x5, pc=0xFFFFFFF0, imm=0x20, pred=1 → taken=1, target=0x00000010, mispredict=0. Then funct3=001 with the same operands → taken=0, redirect=0xFFFFFFF4.
- Back-pressure: 3 back-to-back branches with out_ready=0 for 4 cycles.
  - Required: only the first is accepted and in_ready=0, outputs stable.
  - Release out_ready: one result per cycle, with br_count incrementing 1,2,3.
- Flush: result held with out_ready=0, then assert flush for one cycle with in_valid=1.
  - Required: next cycle out_valid=0, input not accepted, br_count unchanged.
- Illegal/misaligned and counters:
  - funct3=010 → illegal=1, no count.
  - Taken branch with imm=0x2 → misaligned=1.
  - CNT_W=4 with 17 mispredicted handshakes → both counters saturate at 15.
  - cnt_clear together with a handshake → both counters 0.
- Async reset: assert reset between clock edges while out_valid=1 and counters are nonzero.
  - Required: all outputs and counters are 0 immediately (before the next edge), and in_ready=1 after deassertion.
